// File: rtl/rst_req_gen.sv
// rtl/rst_req_gen.sv - merges ndmreset, software and watchdog sources into one stretched reset request
// Runs on the power-on domain so its state and cause bits survive the system reset it requests.

module rst_req_gen #(
    parameter int unsigned STRETCH = 16,
    parameter int unsigned WDOG_W  = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              ndmreset_req_i,
    input  logic              sw_rst_req_i,
    input  logic              wdog_en_i,
    input  logic              wdog_kick_i,
    input  logic [WDOG_W-1:0] wdog_limit_i,
    input  logic              cause_clr_i,
    output logic              rst_req_o,
    output logic [2:0]        rst_cause_o,
    output logic [WDOG_W-1:0] wdog_count_o
);

    localparam int unsigned CNT_W = $clog2(STRETCH + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ASSERT = 2'd1,
        HOLD   = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] stretch_cnt;

    logic       wdog_armed;
    logic       bite;
    logic       trigger;
    logic       accept;
    logic [2:0] cause_set;

    assign wdog_armed = wdog_en_i && (wdog_limit_i != '0);
    // >= rather than == so that lowering the limit below the count still bites
    assign bite       = wdog_armed && (wdog_count_o >= wdog_limit_i);
    assign trigger    = ndmreset_req_i | sw_rst_req_i | bite;
    assign accept     = (state == IDLE) && trigger;
    assign cause_set  = {bite, sw_rst_req_i, ndmreset_req_i};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state       <= IDLE;
            stretch_cnt <= '0;
            rst_req_o   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (trigger) begin
                        state       <= ASSERT;
                        stretch_cnt <= CNT_W'(STRETCH);
                        rst_req_o   <= 1'b1;
                    end else begin
                        rst_req_o   <= 1'b0;
                    end
                end
                ASSERT: begin
                    if (stretch_cnt == CNT_W'(1)) begin
                        if (ndmreset_req_i) begin
                            state     <= HOLD;
                            rst_req_o <= 1'b1;
                        end else begin
                            state     <= IDLE;
                            rst_req_o <= 1'b0;
                        end
                    end else begin
                        stretch_cnt <= stretch_cnt - 1'b1;
                        rst_req_o   <= 1'b1;
                    end
                end
                HOLD: begin
                    if (ndmreset_req_i) begin
                        rst_req_o <= 1'b1;
                    end else begin
                        state     <= IDLE;
                        rst_req_o <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    rst_req_o <= 1'b0;
                end
            endcase
        end
    end

    // Cause bits: a set in the same cycle as a clear wins for that bit only
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rst_cause_o <= 3'b000;
        end else begin
            rst_cause_o <= (cause_clr_i ? 3'b000 : rst_cause_o) | cause_set;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wdog_count_o <= '0;
        end else if (!wdog_en_i || wdog_kick_i || bite || accept) begin
            wdog_count_o <= '0;
        end else if ((state == IDLE) && wdog_armed && (wdog_count_o != '1)) begin
            wdog_count_o <= wdog_count_o + 1'b1;
        end
    end

endmodule

// File: tb/tb_rst_req_gen.sv
// tb/tb_rst_req_gen.sv - randomized and directed bench for rst_req_gen against a behavioural model

module tb_rst_req_gen;

    localparam int unsigned STRETCH = 16;
    localparam int unsigned WDOG_W  = 32;

    logic              clk_i = 1'b0;
    logic              rst_ni;
    logic              ndmreset_req_i, sw_rst_req_i, wdog_en_i, wdog_kick_i, cause_clr_i;
    logic [WDOG_W-1:0] wdog_limit_i;
    logic              rst_req_o;
    logic [2:0]        rst_cause_o;
    logic [WDOG_W-1:0] wdog_count_o;

    logic              ndm1, sw1, en1, kick1, clr1;
    logic [WDOG_W-1:0] limit1;
    logic              req1;
    logic [2:0]        cause1;
    logic [WDOG_W-1:0] count1;

    rst_req_gen #(.STRETCH(STRETCH), .WDOG_W(WDOG_W)) u_dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .ndmreset_req_i(ndmreset_req_i), .sw_rst_req_i(sw_rst_req_i),
        .wdog_en_i(wdog_en_i), .wdog_kick_i(wdog_kick_i), .wdog_limit_i(wdog_limit_i),
        .cause_clr_i(cause_clr_i), .rst_req_o(rst_req_o), .rst_cause_o(rst_cause_o),
        .wdog_count_o(wdog_count_o)
    );

    rst_req_gen #(.STRETCH(1), .WDOG_W(WDOG_W)) u_dut1 (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .ndmreset_req_i(ndm1), .sw_rst_req_i(sw1),
        .wdog_en_i(en1), .wdog_kick_i(kick1), .wdog_limit_i(limit1),
        .cause_clr_i(clr1), .rst_req_o(req1), .rst_cause_o(cause1),
        .wdog_count_o(count1)
    );

    always #5 clk_i = ~clk_i;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: request = "owed stretch cycles, then held while ndmreset stays high"
    bit          m_busy;
    int          m_age;
    bit          m_held;
    bit          m_req;
    logic [2:0]  m_cause;
    logic [31:0] m_count;

    task automatic model_reset();
        m_busy = 0; m_age = 0; m_held = 0; m_req = 0;
        m_cause = 3'b000; m_count = 32'd0;
    endtask

    task automatic model_edge();
        bit bite, trig, was_idle;
        bite     = wdog_en_i && (wdog_limit_i != 0) && (m_count >= wdog_limit_i);
        trig     = ndmreset_req_i || sw_rst_req_i || bite;
        was_idle = !m_busy;
        m_cause  = (cause_clr_i ? 3'b000 : m_cause) | {bite, sw_rst_req_i, ndmreset_req_i};
        if (!wdog_en_i || wdog_kick_i || bite || (was_idle && trig))
            m_count = 0;
        else if (was_idle && wdog_limit_i != 0 && m_count != 32'hffff_ffff)
            m_count = m_count + 1;
        if (m_busy) begin
            m_age++;
            if (m_age >= int'(STRETCH)) begin
                m_held = m_held && ndmreset_req_i;
                if (!m_held) m_busy = 0;
            end
        end else if (trig) begin
            m_busy = 1; m_age = 0; m_held = 1;
        end
        m_req = m_busy;
    endtask

    task automatic step();
        @(posedge clk_i);
        model_edge();
        #1;
        check("rst_req", rst_req_o, m_req);
        check("cause", rst_cause_o, m_cause);
        check("wdog_count", wdog_count_o, m_count);
    endtask

    task automatic idle_steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic clear_cause();
        cause_clr_i = 1; step(); cause_clr_i = 0;
    endtask

    int hi, n1, steps;
    bit saw, done;

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_ni = 0;
        ndmreset_req_i = 0; sw_rst_req_i = 0; wdog_en_i = 0; wdog_kick_i = 0;
        wdog_limit_i = 0; cause_clr_i = 0;
        ndm1 = 0; sw1 = 0; en1 = 0; kick1 = 0; clr1 = 0; limit1 = 0;
        model_reset();
        #12;
        check("reset_req", rst_req_o, 1'b0);
        check("reset_cause", rst_cause_o, 3'b000);
        check("reset_count", wdog_count_o, 32'd0);
        check("reset_req1", req1, 1'b0);
        #10 rst_ni = 1;

        // software request: exactly STRETCH cycles, cause 010
        idle_steps(9);
        sw_rst_req_i = 1; step(); sw_rst_req_i = 0;
        hi = rst_req_o ? 1 : 0;
        for (int i = 0; i < 30; i++) begin step(); if (rst_req_o) hi++; end
        check("sw_len", hi, 16);
        check("sw_cause", rst_cause_o, 3'b010);

        // ndmreset held 36 cycles with a sw pulse inside: 36 request cycles, cause 011
        clear_cause();
        hi = 0;
        ndmreset_req_i = 1;
        for (int i = 0; i < 36; i++) begin
            sw_rst_req_i = (i == 15);
            step();
            if (rst_req_o) hi++;
        end
        ndmreset_req_i = 0; sw_rst_req_i = 0;
        for (int i = 0; i < 20; i++) begin step(); if (rst_req_o) hi++; end
        check("ndm_len", hi, 36);
        check("ndm_cause", rst_cause_o, 3'b011);

        // watchdog bite after limit cycles, request on the following edge
        clear_cause();
        wdog_limit_i = 100; wdog_en_i = 1;
        steps = 0; done = 0;
        for (int i = 0; i < 300 && !done; i++) begin
            step(); steps++;
            if (rst_req_o) done = 1;
        end
        check("bite_latency", steps, 101);
        check("bite_cause", rst_cause_o[2], 1'b1);
        wdog_en_i = 0; idle_steps(20);

        // regular kicks keep the watchdog from biting
        clear_cause();
        wdog_en_i = 1; saw = 0;
        for (int i = 0; i < 1000; i++) begin
            wdog_kick_i = (i % 50 == 49);
            step();
            if (rst_req_o) saw = 1;
        end
        wdog_kick_i = 0;
        check("kick_no_bite", saw, 1'b0);

        // lowering the limit below the count bites immediately
        wdog_en_i = 0; step();
        clear_cause();
        wdog_en_i = 1; wdog_limit_i = 100;
        idle_steps(20);
        check("count_at_20", wdog_count_o, 32'd20);
        wdog_limit_i = 5; step();
        check("lowered_bite", rst_req_o, 1'b1);
        check("lowered_cause", rst_cause_o, 3'b100);
        wdog_en_i = 0; idle_steps(20);

        // set and clear in the same cycle
        ndmreset_req_i = 1; step(); ndmreset_req_i = 0;
        idle_steps(20);
        check("cause_101", rst_cause_o, 3'b101);
        sw_rst_req_i = 1; cause_clr_i = 1; step(); sw_rst_req_i = 0; cause_clr_i = 0;
        check("set_beats_clr", rst_cause_o, 3'b010);
        idle_steps(20);

        // ndmreset and sw together: one request, both cause bits
        clear_cause();
        ndmreset_req_i = 1; sw_rst_req_i = 1; step(); ndmreset_req_i = 0; sw_rst_req_i = 0;
        hi = rst_req_o ? 1 : 0;
        for (int i = 0; i < 30; i++) begin step(); if (rst_req_o) hi++; end
        check("dual_len", hi, 16);
        check("dual_cause", rst_cause_o, 3'b011);

        // asynchronous reset in the middle of a stretch
        sw_rst_req_i = 1; step(); sw_rst_req_i = 0;
        idle_steps(6);
        #2 rst_ni = 0;
        #1;
        check("async_req", rst_req_o, 1'b0);
        check("async_cause", rst_cause_o, 3'b000);
        model_reset();
        #10 rst_ni = 1;
        sw_rst_req_i = 1; step(); sw_rst_req_i = 0;
        hi = rst_req_o ? 1 : 0;
        for (int i = 0; i < 30; i++) begin step(); if (rst_req_o) hi++; end
        check("post_reset_len", hi, 16);

        // limit 0 disables the bite
        wdog_limit_i = 0; wdog_en_i = 1; saw = 0;
        for (int i = 0; i < 200; i++) begin step(); if (rst_req_o) saw = 1; end
        check("limit0_count", wdog_count_o, 32'd0);
        check("limit0_no_bite", saw, 1'b0);
        wdog_en_i = 0;

        // 1-cycle ndmreset gives exactly STRETCH cycles
        ndmreset_req_i = 1; step(); ndmreset_req_i = 0;
        hi = rst_req_o ? 1 : 0;
        for (int i = 0; i < 30; i++) begin step(); if (rst_req_o) hi++; end
        check("ndm_pulse_len", hi, 16);

        // STRETCH=1 instance
        sw1 = 1; step(); sw1 = 0;
        n1 = req1 ? 1 : 0;
        for (int i = 0; i < 5; i++) begin step(); if (req1) n1++; end
        check("s1_sw_len", n1, 1);
        ndm1 = 1; step(); ndm1 = 0;
        n1 = req1 ? 1 : 0;
        for (int i = 0; i < 5; i++) begin step(); if (req1) n1++; end
        check("s1_ndm_len", n1, 1);
        ndm1 = 1; n1 = 0;
        for (int i = 0; i < 3; i++) begin step(); if (req1) n1++; end
        ndm1 = 0;
        for (int i = 0; i < 5; i++) begin step(); if (req1) n1++; end
        check("s1_ndm_hold_len", n1, 3);

        // randomized traffic
        wdog_en_i = 1; wdog_limit_i = 32'($urandom_range(0, 60));
        for (int i = 0; i < 3000; i++) begin
            if (ndmreset_req_i) ndmreset_req_i = ($urandom % 8) != 0;
            else                ndmreset_req_i = ($urandom % 60) == 0;
            sw_rst_req_i = ($urandom % 40) == 0;
            wdog_kick_i  = ($urandom % 30) == 0;
            cause_clr_i  = ($urandom % 25) == 0;
            if (($urandom % 200) == 0) wdog_en_i = ~wdog_en_i;
            if (($urandom % 100) == 0) wdog_limit_i = 32'($urandom_range(0, 60));
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
